// File: rtl/mips_multicycle_ctrl.sv
// ----------------------------------------------------------------------------
// mips_multicycle_ctrl
//
// Moore-style control sequencer for a multicycle MIPS subset
// (add/sub/and/or/nor/slt, lw, sw, beq, addi, j). Each cycle it issues one
// control word for the shared datapath, derived from the current state only,
// except that ir_write/pc_en in FETCH follow mem_ready.
//
// Memory handshake: mem_req is held high for the whole access. The access
// completes on the first rising edge where mem_req=1 and mem_ready=1;
// mem_we is only meaningful while mem_req=1. An access that sees MAX_WAIT
// consecutive cycles without mem_ready is abandoned: the FSM returns to
// FETCH and mem_timeout sets and stays set until reset.
//
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   opcode, funct      IR[31:26], IR[5:0]
//   zero               ALU zero flag (branch decision)
//   mem_ready          memory completes access this cycle
//   mem_req, mem_we    memory request / write strobe
//   iord               address select (0=PC, 1=ALUOut)
//   ir_write, pc_en    IR load, PC load
//   pc_src             PC source (00=ALU, 01=ALUOut, 10=jump target)
//   reg_write, reg_dst, mem_to_reg   register file write controls
//   alu_src_a, alu_src_b, alu_ctrl   ALU operand selects and operation
//   state              current state encoding (debug)
//   illegal            one-cycle pulse on unsupported opcode/funct
//   mem_timeout        sticky memory timeout flag
// ----------------------------------------------------------------------------
module mips_multicycle_ctrl #(
    parameter int MAX_WAIT = 255,
    parameter int WAIT_W   = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_we,
    output logic       iord,
    output logic       ir_write,
    output logic       pc_en,
    output logic [1:0] pc_src,
    output logic       reg_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [3:0] alu_ctrl,
    output logic [3:0] state,
    output logic       illegal,
    output logic       mem_timeout
);

    localparam logic [3:0] S_FETCH  = 4'd0;
    localparam logic [3:0] S_DECODE = 4'd1;
    localparam logic [3:0] S_MEMADR = 4'd2;
    localparam logic [3:0] S_MEMRD  = 4'd3;
    localparam logic [3:0] S_MEMWB  = 4'd4;
    localparam logic [3:0] S_MEMWR  = 4'd5;
    localparam logic [3:0] S_EXEC   = 4'd6;
    localparam logic [3:0] S_ALUWB  = 4'd7;
    localparam logic [3:0] S_BRANCH = 4'd8;
    localparam logic [3:0] S_ADDIEX = 4'd9;
    localparam logic [3:0] S_ADDIWB = 4'd10;
    localparam logic [3:0] S_JUMP   = 4'd11;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [3:0] ALU_AND = 4'd0;
    localparam logic [3:0] ALU_OR  = 4'd1;
    localparam logic [3:0] ALU_ADD = 4'd2;
    localparam logic [3:0] ALU_SUB = 4'd3;
    localparam logic [3:0] ALU_SLT = 4'd7;
    localparam logic [3:0] ALU_NOR = 4'd12;

    // Counter value on the last tolerated waiting cycle.
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MAX_WAIT - 1);

    logic [3:0]        state_q, state_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic              timeout_q, timeout_d;
    logic              funct_ok;
    logic [3:0]        funct_alu;
    logic              waiting;
    logic              expire;

    // R-type funct decode shared by DECODE (legality) and EXEC (operation).
    always_comb begin
        funct_ok  = 1'b1;
        funct_alu = ALU_ADD;
        case (funct)
            6'h20:   funct_alu = ALU_ADD;
            6'h22:   funct_alu = ALU_SUB;
            6'h24:   funct_alu = ALU_AND;
            6'h25:   funct_alu = ALU_OR;
            6'h27:   funct_alu = ALU_NOR;
            6'h2A:   funct_alu = ALU_SLT;
            default: funct_ok  = 1'b0;
        endcase
    end

    // Control word per state.
    always_comb begin
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        iord       = 1'b0;
        ir_write   = 1'b0;
        pc_en      = 1'b0;
        pc_src     = 2'b00;
        reg_write  = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'b00;
        alu_ctrl   = 4'd0;
        case (state_q)
            S_FETCH: begin
                mem_req   = 1'b1;
                alu_src_b = 2'b01;
                alu_ctrl  = ALU_ADD;
                ir_write  = mem_ready;
                pc_en     = mem_ready;
            end
            S_DECODE: begin
                alu_src_b = 2'b11;
                alu_ctrl  = ALU_ADD;
            end
            S_MEMADR, S_ADDIEX: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                alu_ctrl  = ALU_ADD;
            end
            S_MEMRD: begin
                mem_req = 1'b1;
                iord    = 1'b1;
            end
            S_MEMWB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
            end
            S_MEMWR: begin
                mem_req = 1'b1;
                mem_we  = 1'b1;
                iord    = 1'b1;
            end
            S_EXEC: begin
                alu_src_a = 1'b1;
                alu_ctrl  = funct_alu;
            end
            S_ALUWB: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a = 1'b1;
                alu_ctrl  = ALU_SUB;
                pc_src    = 2'b01;
                pc_en     = zero;
            end
            S_ADDIWB: reg_write = 1'b1;
            S_JUMP: begin
                pc_src = 2'b10;
                pc_en  = 1'b1;
            end
            default: ;
        endcase
    end

    assign waiting = mem_req & ~mem_ready;
    // mem_ready on the last tolerated cycle still counts as completion.
    assign expire  = waiting & (wait_q == WAIT_LAST);

    // Next state, illegal pulse, wait counter and timeout flag.
    always_comb begin
        state_d = state_q;
        illegal = 1'b0;
        case (state_q)
            S_FETCH:  if (mem_ready) state_d = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    OP_RTYPE: begin
                        if (funct_ok) begin
                            state_d = S_EXEC;
                        end else begin
                            illegal = 1'b1;
                            state_d = S_FETCH;
                        end
                    end
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_ADDI:      state_d = S_ADDIEX;
                    OP_J:         state_d = S_JUMP;
                    default: begin
                        illegal = 1'b1;
                        state_d = S_FETCH;
                    end
                endcase
            end
            S_MEMADR: state_d = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:  if (mem_ready) state_d = S_MEMWB;
            S_MEMWR:  if (mem_ready) state_d = S_FETCH;
            S_EXEC:   state_d = S_ALUWB;
            S_ADDIEX: state_d = S_ADDIWB;
            default:  state_d = S_FETCH;  // write-back, BRANCH, JUMP, 12-15
        endcase
        if (expire) state_d = S_FETCH;

        if (mem_ready || expire || (state_d != state_q)) begin
            wait_d = '0;
        end else if (waiting) begin
            wait_d = wait_q + WAIT_W'(1);
        end else begin
            wait_d = wait_q;
        end
        timeout_d = timeout_q | expire;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_FETCH;
            wait_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            timeout_q <= timeout_d;
        end
    end

    assign state       = state_q;
    assign mem_timeout = timeout_q;

endmodule

// File: doc/mips_multicycle_ctrl.md
Name: mips_multicycle_ctrl

Overview:
Moore-style control FSM that sequences the shared datapath (PC, memory port, instruction register, register file, ALU, two-to-one muxes, sign extender) as a multicycle MIPS subset: R-type add/sub/and/or/nor/slt, lw, sw, beq, addi, j. It issues one control word per cycle from the current state and handshakes with the memory port. It also raises a sticky timeout if memory never responds.

Parameters:
MAX_WAIT, 255, max cycles a state waits for mem_ready before abandoning the access
WAIT_W, 8, width of the wait counter; must hold MAX_WAIT

Ports:
clk  in  1  clock, all state updates on rising edge
rst_n  in  1  asynchronous active-low reset
opcode  in  6  IR[31:26]
funct  in  6  IR[5:0]
zero  in  1  ALU zero flag
mem_ready  in  1  memory completes access this cycle
mem_req  out  1  memory access request
mem_we  out  1  write strobe, valid with mem_req
iord  out  1  address select: 0=PC, 1=ALUOut
ir_write  out  1  load IR
pc_en  out  1  load PC
pc_src  out  2  00=ALU result, 01=ALUOut, 10=jump target
reg_write  out  1  register file write enable
reg_dst  out  1  0=rt, 1=rd
mem_to_reg  out  1  0=ALUOut, 1=MDR
alu_src_a  out  1  0=PC, 1=regA
alu_src_b  out  2  00=regB, 01=const 4, 10=signext imm, 11=signext imm<<2
alu_ctrl  out  4  0=AND, 1=OR, 2=ADD, 3=SUB, 7=SLT, 12=NOR
state  out  4  current state encoding (debug)
illegal  out  1  one-cycle pulse: unsupported opcode/funct
mem_timeout  out  1  sticky: an access exceeded MAX_WAIT

Behaviour:
- Reset (async, rst_n=0): state=FETCH, wait counter=0, mem_timeout=0, illegal=0. Every output is the FETCH control word with mem_ready gating; outputs not listed for a state are 0.
- Encodings: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, ALUWB=7, BRANCH=8, ADDIEX=9, ADDIWB=10, JUMP=11. Encodings 12-15 go to FETCH on the next edge.
- FETCH: mem_req=1, iord=0, alu_src_a=0, alu_src_b=01, alu_ctrl=2, pc_src=00. ir_write=pc_en=mem_ready. Go to DECODE when mem_ready=1, otherwise hold.
- DECODE: alu_src_a=0, alu_src_b=11, alu_ctrl=2 (precomputes branch target). Next state by opcode: 0x00→EXEC if funct ∈ {0x20,0x22,0x24,0x25,0x27,0x2A}; 0x23 or 0x2B→MEMADR; 0x04→BRANCH; 0x08→ADDIEX; 0x02→JUMP. Any other opcode or funct: illegal=1 for this cycle, next state FETCH, no register/PC/memory writes.
- MEMADR: alu_src_a=1, alu_src_b=10, alu_ctrl=2. Next state MEMRD for lw, MEMWR for sw.
- MEMRD: mem_req=1, iord=1. Hold until mem_ready, then go to MEMWB.
- MEMWB: reg_write=1, reg_dst=0, mem_to_reg=1. Next state FETCH.
- MEMWR: mem_req=1, mem_we=1, iord=1. Hold until mem_ready, then go to FETCH.
- EXEC: alu_src_a=1, alu_src_b=00, alu_ctrl from funct: 0x20→2, 0x22→3, 0x24→0, 0x25→1, 0x27→12, 0x2A→7. Next state ALUWB.
- ALUWB: reg_write=1, reg_dst=1, mem_to_reg=0. Next state FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_ctrl=3, pc_src=01, pc_en=zero. Next state FETCH.
- ADDIEX: alu_src_a=1, alu_src_b=10, alu_ctrl=2. Next state ADDIWB.
- ADDIWB: reg_write=1, reg_dst=0, mem_to_reg=0. Next state FETCH.
- JUMP: pc_src=10, pc_en=1. Next state FETCH.
- Wait counter: increments each cycle mem_req=1 and mem_ready=0. It clears on mem_ready or on any state change.
  - When the counter reaches MAX_WAIT with mem_ready still 0: mem_timeout is set, next state is FETCH, and no ir_write, pc_en or reg_write occurs for the abandoned access.
  - mem_ready arriving on the same cycle the counter reaches MAX_WAIT is treated as completion.
- Latency with zero-wait memory (mem_ready tied 1): lw 5 cycles; sw, R-type and addi 4 cycles; beq and j 3 cycles.
- rst_n deassertion mid-instruction: the next rising edge begins in FETCH; no partial write completes.

Test Plan:
- mem_ready=1, opcode=0x00 funct=0x20 → states 0,1,6,7,0; alu_ctrl=2 in EXEC; reg_write=1 and reg_dst=1 only in ALUWB.
- lw (0x23) with mem_ready low for 3 cycles in MEMRD → state holds 3 at mem_req=1/iord=1 for 4 cycles total, then MEMWB with mem_to_reg=1; 8 cycles total.
- beq (0x04): zero=1 → pc_en=1, pc_src=01 in BRANCH; zero=0 → pc_en=0. Both return to FETCH after 3 cycles.
- opcode=0x3F → illegal pulses exactly 1 cycle in DECODE, next state 0; reg_write, pc_en and mem_we stay 0.
- MAX_WAIT=4, mem_ready held 0 in FETCH → after 4 waiting cycles mem_timeout=1 (sticky), state stays 0, ir_write never asserted.
- rst_n pulsed low in EXEC of an R-type → state=0 immediately (asynchronously), mem_timeout=0, no reg_write issued.
